// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use/branch/RAW stalls, operand forwarding, multi-cycle mul/div hold.
// Stall and forward outputs are combinational; md_busy follows md_start by one edge for md_len-1 cycles.
// The unit is itself the backpressure source; it never waits on anything downstream.
// Build option: define HAZARD_FWD_EN to enable forwarding; without it, RAW hazards on E/M stall instead.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  Rs_D,
   input  logic [4:0]  Rt_D,
   input  logic [4:0]  Rs_E,
   input  logic [4:0]  Rt_E,
   input  logic [4:0]  WriteReg_E,
   input  logic [4:0]  WriteReg_M,
   input  logic [4:0]  WriteReg_W,
   input  logic        RegWrite_E,
   input  logic        RegWrite_M,
   input  logic        RegWrite_W,
   input  logic        MemToReg_E,
   input  logic        MemToReg_M,
   input  logic        Branch_D,
   input  logic        md_start,
   input  logic [5:0]  md_len,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushE,
   output logic [1:0]  ForwardA_E,
   output logic [1:0]  ForwardB_E,
   output logic        ForwardA_D,
   output logic        ForwardB_D,
   output logic        md_busy,
   output logic [15:0] stall_cnt
);

   typedef enum logic {RUN, MD_WAIT} md_state_t;

   md_state_t  state_q, state_d;
   logic [5:0] md_cnt_q, md_cnt_d;
   logic       lwstall, brstall, rawstall, stall;

   // $0 is hardwired to zero, so it never creates a dependency
   function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   logic hit_d_e, hit_d_m;
   assign hit_d_e = reg_hit(Rs_D, WriteReg_E) | reg_hit(Rt_D, WriteReg_E);
   assign hit_d_m = reg_hit(Rs_D, WriteReg_M) | reg_hit(Rt_D, WriteReg_M);

   // load in EX feeding the instruction in ID cannot be forwarded in time
   assign lwstall = MemToReg_E & RegWrite_E & hit_d_e;

   // branches compare in ID, so ALU results in EX and loads in MEM are too late
   assign brstall = Branch_D & ((RegWrite_E & hit_d_e) | (MemToReg_M & hit_d_m));

`ifdef HAZARD_FWD_EN
   assign rawstall = 1'b0;

   // EX operand select, MEM result wins over WB since it is younger
   always_comb begin
      ForwardA_E = 2'b00;
      ForwardB_E = 2'b00;
      if (RegWrite_M && reg_hit(Rs_E, WriteReg_M))
         ForwardA_E = 2'b10;
      else if (RegWrite_W && reg_hit(Rs_E, WriteReg_W))
         ForwardA_E = 2'b01;
      if (RegWrite_M && reg_hit(Rt_E, WriteReg_M))
         ForwardB_E = 2'b10;
      else if (RegWrite_W && reg_hit(Rt_E, WriteReg_W))
         ForwardB_E = 2'b01;
   end

   assign ForwardA_D = RegWrite_M & reg_hit(Rs_D, WriteReg_M);
   assign ForwardB_D = RegWrite_M & reg_hit(Rt_D, WriteReg_M);
`else
   // no bypass paths: any pending write in EX or MEM must drain before ID reads
   assign rawstall   = (RegWrite_E & hit_d_e) | (RegWrite_M & hit_d_m);
   assign ForwardA_E = 2'b00;
   assign ForwardB_E = 2'b00;
   assign ForwardA_D = 1'b0;
   assign ForwardB_D = 1'b0;

   logic unused_fwd;
   assign unused_fwd = ^{Rs_E, Rt_E, WriteReg_W, RegWrite_W};
`endif

   assign md_busy = (state_q == MD_WAIT);
   assign stall   = lwstall | brstall | rawstall | md_busy;
   assign StallF  = stall;
   assign StallD  = stall;
   assign FlushE  = stall;

   // mul/div sequencing: md_cnt counts the remaining busy cycles
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         RUN: begin
            if (md_start && (md_len >= 6'd2)) begin
               state_d  = MD_WAIT;
               md_cnt_d = md_len - 6'd1;
            end
         end
         MD_WAIT: begin
            md_cnt_d = md_cnt_q - 6'd1;
            if (md_cnt_q == 6'd1)
               state_d = RUN;
         end
      endcase
   end

   // FSM state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         md_cnt_q <= 6'd0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   // saturating count of stalled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= 16'd0;
      else if (StallD && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural reference model.
// Inputs change 1 time unit after the rising edge, outputs are compared on the falling edge.
// Compile with or without HAZARD_FWD_EN; the reference model follows the same option.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E;
   logic [4:0]  WriteReg_E, WriteReg_M, WriteReg_W;
   logic        RegWrite_E, RegWrite_M, RegWrite_W;
   logic        MemToReg_E, MemToReg_M, Branch_D, md_start;
   logic [5:0]  md_len;
   logic        StallF, StallD, FlushE;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic        ForwardA_D, ForwardB_D, md_busy;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state: cycles of mul/div hold still owed, total stalled edges
   int busy_left = 0;
   int stall_total = 0;

   // expectations derived from current inputs and model state
   bit       e_stall, e_fad, e_fbd;
   bit [1:0] e_fae, e_fbe;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
      .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
      .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M), .Branch_D(Branch_D),
      .md_start(md_start), .md_len(md_len),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
      return (src != 0) && (src == dst);
   endfunction

   function automatic bit [1:0] fwd_e(input logic [4:0] src);
      if (RegWrite_M && dep(src, WriteReg_M)) return 2'd2;
      if (RegWrite_W && dep(src, WriteReg_W)) return 2'd1;
      return 2'd0;
   endfunction

   task automatic calc_expect();
      bit d_e, d_m, lw, br, raw;
      d_e = dep(Rs_D, WriteReg_E) || dep(Rt_D, WriteReg_E);
      d_m = dep(Rs_D, WriteReg_M) || dep(Rt_D, WriteReg_M);
      lw  = MemToReg_E && RegWrite_E && d_e;
      br  = Branch_D && ((RegWrite_E && d_e) || (MemToReg_M && d_m));
`ifdef HAZARD_FWD_EN
      raw   = 1'b0;
      e_fae = fwd_e(Rs_E);
      e_fbe = fwd_e(Rt_E);
      e_fad = RegWrite_M && dep(Rs_D, WriteReg_M);
      e_fbd = RegWrite_M && dep(Rt_D, WriteReg_M);
`else
      raw   = (RegWrite_E && d_e) || (RegWrite_M && d_m);
      e_fae = 2'd0;
      e_fbe = 2'd0;
      e_fad = 1'b0;
      e_fbd = 1'b0;
`endif
      e_stall = lw || br || raw || (busy_left > 0);
   endtask

   task automatic check_all(input string tag);
      calc_expect();
      check({tag, ".StallF"}, int'(StallF), int'(e_stall));
      check({tag, ".StallD"}, int'(StallD), int'(e_stall));
      check({tag, ".FlushE"}, int'(FlushE), int'(e_stall));
      check({tag, ".FwdA_E"}, int'(ForwardA_E), int'(e_fae));
      check({tag, ".FwdB_E"}, int'(ForwardB_E), int'(e_fbe));
      check({tag, ".FwdA_D"}, int'(ForwardA_D), int'(e_fad));
      check({tag, ".FwdB_D"}, int'(ForwardB_D), int'(e_fbd));
      check({tag, ".md_busy"}, int'(md_busy), int'(busy_left > 0));
      check({tag, ".stall_cnt"}, int'(stall_cnt), (stall_total > 65535) ? 65535 : stall_total);
   endtask

   // advance the model across one rising edge, using the inputs present at that edge
   task automatic model_edge();
      calc_expect();
      if (e_stall) stall_total++;
      if (busy_left > 0) busy_left--;
      else if (md_start && md_len >= 2) busy_left = int'(md_len) - 1;
   endtask

   task automatic step(input string tag);
      @(negedge clk);
      check_all(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic zero_inputs();
      Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0;
      WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
      RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
      MemToReg_E = 0; MemToReg_M = 0; Branch_D = 0;
      md_start = 0; md_len = 0;
   endtask

   // reset pulse placed between edges; outputs are checked while reset is held
   task automatic pulse_reset(input string tag);
      #1 rst_n = 1'b0;
      busy_left = 0;
      stall_total = 0;
      #1 check_all(tag);
      check({tag, ".busy_now"}, int'(md_busy), 0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      zero_inputs();
      rst_n = 1'b0;
      RegWrite_M = 1; WriteReg_M = 8; Rs_E = 8;
      #2 check_all("reset");
      #1 rst_n = 1'b1;
      zero_inputs();
      @(posedge clk);
      model_edge();
      #1;

      // load-use stall on Rs_D
      MemToReg_E = 1; RegWrite_E = 1; WriteReg_E = 5; Rs_D = 5;
      step("lwuse");
      zero_inputs();
      step("lwuse_after");
      check("lwuse_cnt", int'(stall_cnt), 1);

      // MEM-over-WB priority, then WB alone
      RegWrite_M = 1; WriteReg_M = 8; RegWrite_W = 1; WriteReg_W = 8; Rs_E = 8;
      step("fwd_mem");
      RegWrite_M = 0;
      step("fwd_wb");
      zero_inputs();

      // $0 never matches
      RegWrite_M = 1; WriteReg_M = 0; Rs_E = 0; Rt_D = 0;
      step("reg0");
      WriteReg_M = 3; Rt_D = 3;
      step("raw_m");
      zero_inputs();

      // mul/div of 4 cycles: three busy cycles, then a single-cycle op with no stall
      md_start = 1; md_len = 4;
      step("md4_start");
      md_start = 0;
      for (int i = 0; i < 5; i++) step("md4");
      md_start = 1; md_len = 1;
      step("md1_start");
      md_start = 0;
      step("md1");
      check("md1_busy", int'(md_busy), 0);

      // reset in the second busy cycle, with forwarding inputs still live
      md_start = 1; md_len = 4;
      step("mdrst_start");
      md_start = 0;
      step("mdrst_w1");
      RegWrite_M = 1; WriteReg_M = 8; Rs_E = 8; Rt_E = 8;
      pulse_reset("mdrst");
      check("mdrst_cnt", int'(stall_cnt), 0);
      step("mdrst_after");
      zero_inputs();

      // random traffic over a small register window so hazards are frequent
      for (int i = 0; i < 1500; i++) begin
         Rs_D = 5'($urandom_range(0, 7)); Rt_D = 5'($urandom_range(0, 7));
         Rs_E = 5'($urandom_range(0, 7)); Rt_E = 5'($urandom_range(0, 7));
         WriteReg_E = 5'($urandom_range(0, 7));
         WriteReg_M = 5'($urandom_range(0, 7));
         WriteReg_W = 5'($urandom_range(0, 7));
         RegWrite_E = 1'($urandom_range(0, 1));
         RegWrite_M = 1'($urandom_range(0, 1));
         RegWrite_W = 1'($urandom_range(0, 1));
         MemToReg_E = 1'($urandom_range(0, 1));
         MemToReg_M = 1'($urandom_range(0, 1));
         Branch_D   = ($urandom_range(0, 3) == 0);
         md_start   = ($urandom_range(0, 7) == 0);
         md_len     = 6'($urandom_range(0, 9));
         step("rand");
      end
      zero_inputs();
      step("rand_end");

      // saturation: hold a load-use stall for more than 65536 edges
      MemToReg_E = 1; RegWrite_E = 1; WriteReg_E = 9; Rt_D = 9;
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      step("sat");
      check("sat_hold", int'(stall_cnt), 16'hFFFF);
      zero_inputs();
      step("sat_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: Rs_D, Rt_D  in  5 each  source registers of instruction in ID.
REQ-004 SHALL provide: Rs_E, Rt_E  in  5 each  source registers of instruction in EX.
REQ-005 SHALL provide: WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination register per stage.
REQ-006 SHALL provide: RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  stage writes register file.
REQ-007 SHALL provide: MemToReg_E, MemToReg_M  in  1 each  stage holds a load.
REQ-008 SHALL provide: Branch_D  in  1  ID holds a branch resolved in ID.
REQ-009 SHALL provide: md_start  in  1  EX holds a multi-cycle mul/div op; md_len  in  6  total op cycles.
REQ-010 SHALL provide: StallF, StallD, FlushE  out  1 each  hold IF/ID, hold ID/EX inputs, bubble ID/EX.
REQ-011 SHALL provide: ForwardA_E, ForwardB_E  out  2 each  EX operand select (00 regfile, 01 WB, 10 MEM).
REQ-012 SHALL provide: ForwardA_D, ForwardB_D  out  1 each  ID branch-compare operand from MEM.
REQ-013 SHALL provide: md_busy  out  1  FSM in MD_WAIT; stall_cnt  out  16  stalled-cycle count.

Function
REQ-014 Register $0 SHALL never match any hazard or forwarding comparison.
REQ-015 lwstall SHALL = MemToReg_E & RegWrite_E & (WriteReg_E==Rs_D | WriteReg_E==Rt_D).
REQ-016 brstall SHALL = Branch_D & ((RegWrite_E & WriteReg_E matches Rs_D/Rt_D) | (MemToReg_M & WriteReg_M matches Rs_D/Rt_D)).
REQ-017 StallF = StallD = FlushE SHALL = lwstall | brstall | md_busy, combinational, same cycle.
REQ-018 ForwardX_E SHALL be 10 if RegWrite_M & WriteReg_M==RsX_E, else 01 if RegWrite_W & WriteReg_W==RsX_E, else 00 (MEM priority).
REQ-019 ForwardX_D SHALL be 1 iff RegWrite_M & WriteReg_M==RsX_D.
REQ-020 FSM states RUN, MD_WAIT; 6-bit down counter md_cnt.
REQ-021 In RUN, md_start with md_len>=2 SHALL load md_cnt=md_len-1 and enter MD_WAIT next edge; md_len 0 or 1 SHALL stay RUN.
REQ-022 In MD_WAIT, md_cnt SHALL decrement each edge; at md_cnt==1 next state SHALL be RUN; md_start ignored.
REQ-023 md_len=N (N>=2) SHALL produce exactly N-1 consecutive md_busy cycles, starting the cycle after md_start.
REQ-024 stall_cnt SHALL increment on each edge where StallD=1, saturating at 16'hFFFF (no wrap).
REQ-025 Simultaneous lwstall/brstall/md_busy SHALL produce a single stall (OR), no extra cycles.

Reset
REQ-026 rst_n=0 SHALL immediately force state RUN, md_cnt=0, stall_cnt=0, md_busy=0, regardless of clk.
REQ-027 Reset asserted during MD_WAIT SHALL drop StallF/StallD/FlushE asynchronously unless lwstall/brstall hold.
REQ-028 Forward outputs are combinational; they SHALL reflect inputs during reset.

Configuration
REQ-029 Macro HAZARD_FWD_EN defined: forwarding per REQ-018/019, stalls per REQ-015/016.
REQ-030 HAZARD_FWD_EN undefined: all Forward outputs SHALL be 0; stall SHALL additionally assert when Rs_D/Rt_D (nonzero) matches WriteReg_E with RegWrite_E or WriteReg_M with RegWrite_M.

Verification
REQ-031 MemToReg_E=1,RegWrite_E=1,WriteReg_E=5,Rs_D=5 -> StallF=StallD=FlushE=1 that cycle, stall_cnt +1.
REQ-032 RegWrite_M=1,WriteReg_M=8,RegWrite_W=1,WriteReg_W=8,Rs_E=8 -> ForwardA_E=10; drop RegWrite_M -> 01.
REQ-033 md_start=1,md_len=4 in RUN -> md_busy/stalls high exactly 3 cycles then RUN; md_len=1 -> no stall.
REQ-034 rst_n pulsed low in 2nd MD_WAIT cycle -> stalls deassert without clock edge, stall_cnt=0.
REQ-035 WriteReg_M=0,RegWrite_M=1,Rs_E=0 -> ForwardA_E=00; HAZARD_FWD_EN undefined, RegWrite_M=1,WriteReg_M=3,Rt_D=3 -> StallD=1.
REQ-036 Force 65536 stalled cycles -> stall_cnt holds 16'hFFFF.
